// File: rtl/hazard_scoreboard.sv
// Register write-in-flight scoreboard: per-GPR outstanding-write counters drive the read-stage stall,
// with a pending mask, a sticky spurious-write-back flag and a saturating stall-cycle counter for debug.
module hazard_scoreboard #(
    parameter int GPR_COUNT       = 8,
    parameter int GPR_SIZE        = 3,
    parameter int CNT_WIDTH       = 2,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       issue_valid,
    input  logic                       dest_valid,
    input  logic [GPR_SIZE-1:0]        dest,
    input  logic                       src0_valid,
    input  logic [GPR_SIZE-1:0]        src0,
    input  logic                       src1_valid,
    input  logic [GPR_SIZE-1:0]        src1,
    input  logic                       wb_valid,
    input  logic [GPR_SIZE-1:0]        wb_address,
    output logic                       stall,
    output logic [GPR_COUNT-1:0]       pending,
    output logic                       wb_error,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    logic [CNT_WIDTH-1:0]       cnt_q [GPR_COUNT];
    logic [CNT_WIDTH-1:0]       cnt_d [GPR_COUNT];
    logic                       wb_error_q, wb_error_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic                       accept;

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < GPR_COUNT; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

    // No write-back bypass: a completion in this cycle does not lift the stall until the next one.
    always_comb begin
        stall = issue_valid &&
                ((src0_valid && pending[src0]) ||
                 (src1_valid && pending[src1]) ||
                 (dest_valid && (cnt_q[dest] == '1)));
    end

    assign accept = issue_valid && !stall && !flush;

    always_comb begin
        for (int unsigned i = 0; i < GPR_COUNT; i++) begin
            logic inc;
            logic dec;
            inc      = accept && dest_valid && (dest == GPR_SIZE'(i));
            dec      = wb_valid && (wb_address == GPR_SIZE'(i)) && (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        wb_error_d = wb_error_q;
        if (wb_valid && !flush && (cnt_q[wb_address] == '0)) begin
            wb_error_d = 1'b1;
        end
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < GPR_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
            wb_error_q     <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            for (int unsigned i = 0; i < GPR_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            wb_error_q     <= wb_error_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign wb_error     = wb_error_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// compared against an integer-array model of outstanding writes per register.
module tb_hazard_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        dest_valid = 1'b0;
    logic [2:0]  dest = '0;
    logic        src0_valid = 1'b0;
    logic [2:0]  src0 = '0;
    logic        src1_valid = 1'b0;
    logic [2:0]  src1 = '0;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_address = '0;
    logic        stall;
    logic [7:0]  pending;
    logic        wb_error;
    logic [15:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    // Reference model: number of writes in flight per register, plus debug state.
    int m_cnt [8];
    bit m_err;
    int m_scnt;

    hazard_scoreboard #(
        .GPR_COUNT(8),
        .GPR_SIZE(3),
        .CNT_WIDTH(2),
        .STALL_CNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .dest_valid(dest_valid), .dest(dest),
        .src0_valid(src0_valid), .src0(src0), .src1_valid(src1_valid), .src1(src1),
        .wb_valid(wb_valid), .wb_address(wb_address),
        .stall(stall), .pending(pending), .wb_error(wb_error), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    function automatic logic model_stall();
        return issue_valid && ((src0_valid && m_cnt[src0] > 0) ||
                               (src1_valid && m_cnt[src1] > 0) ||
                               (dest_valid && m_cnt[dest] == 3));
    endfunction

    function automatic logic [7:0] model_pending();
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (m_cnt[i] > 0) p[i] = 1'b1;
        return p;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_err = 0;
        m_scnt = 0;
    endtask

    task automatic idle_inputs();
        flush = 0; issue_valid = 0; dest_valid = 0; dest = 0;
        src0_valid = 0; src0 = 0; src1_valid = 0; src1 = 0;
        wb_valid = 0; wb_address = 0;
    endtask

    // Drive inputs shortly after the falling edge, leaving time for stall to settle.
    task automatic set_inputs(input logic iv, input logic dv, input logic [2:0] d,
                              input logic s0v, input logic [2:0] s0,
                              input logic s1v, input logic [2:0] s1,
                              input logic wv, input logic [2:0] wa, input logic fl);
        @(negedge clock);
        issue_valid = iv; dest_valid = dv; dest = d;
        src0_valid = s0v; src0 = s0; src1_valid = s1v; src1 = s1;
        wb_valid = wv; wb_address = wa; flush = fl;
        #1;
    endtask

    // Advance one rising edge and step the model with the inputs that were presented.
    task automatic clock_edge();
        int  nxt [8];
        bit  st, acc;
        st  = model_stall();
        acc = issue_valid && !st && !flush;
        for (int i = 0; i < 8; i++) begin
            nxt[i] = m_cnt[i];
            if (flush) nxt[i] = 0;
            else begin
                if (acc && dest_valid && dest == i) nxt[i] = nxt[i] + 1;
                if (wb_valid && wb_address == i && m_cnt[i] > 0) nxt[i] = nxt[i] - 1;
            end
        end
        if (wb_valid && !flush && m_cnt[wb_address] == 0) m_err = 1;
        if (st && m_scnt < 65535) m_scnt = m_scnt + 1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) m_cnt[i] = nxt[i];
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1;
        #1;
        model_clear();
        #2;
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_reset();
        @(negedge clock);
        issue_valid = 1'($urandom); dest_valid = 1'($urandom); dest = 3'($urandom);
        src0_valid = 1'($urandom); src0 = 3'($urandom); src1_valid = 1'($urandom);
        src1 = 3'($urandom); wb_valid = 1'($urandom); wb_address = 3'($urandom);
        reset = 1;
        #1;
        model_clear();
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL reset_pending got=%h exp=00", pending); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (wb_error !== 1'b0) begin failures++; $display("FAIL reset_wb_error got=%b exp=0", wb_error); end
        checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
        #2;
        reset = 0;
        set_inputs(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_src0_stall got=%b exp=0", stall); end
        clock_edge();
        idle_inputs();
    endtask

    task automatic test_raw();
        do_reset();
        set_inputs(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_c1_stall got=%b exp=0", stall); end
        clock_edge();
        checks++; if (pending !== 8'h20) begin failures++; $display("FAIL raw_pending got=%h exp=20", pending); end
        set_inputs(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_c2_stall got=%b exp=1", stall); end
        clock_edge();
        set_inputs(1, 0, 0, 0, 0, 1, 5, 1, 5, 0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_c3_no_bypass got=%b exp=1", stall); end
        clock_edge();
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_c4_stall got=%b exp=0", stall); end
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL raw_c4_pending got=%h exp=00", pending); end
        checks++; if (stall_cycles !== 16'd2) begin failures++; $display("FAIL raw_stall_cycles got=%0d exp=2", stall_cycles); end
        clock_edge();
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_inputs(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sat_fill%0d_stall got=%b exp=0", k, stall); end
            clock_edge();
        end
        checks++; if (pending !== 8'h04) begin failures++; $display("FAIL sat_pending got=%h exp=04", pending); end
        set_inputs(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_full_stall got=%b exp=1", stall); end
        clock_edge();
        set_inputs(1, 1, 2, 0, 0, 0, 0, 1, 2, 0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_wb_cycle_stall got=%b exp=1", stall); end
        clock_edge();
        set_inputs(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sat_after_wb_stall got=%b exp=0", stall); end
        clock_edge();
        set_inputs(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_refull_stall got=%b exp=1", stall); end
        checks++; if (m_cnt[2] != 3) begin failures++; $display("FAIL sat_model_cnt got=%0d exp=3", m_cnt[2]); end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_inputs(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        clock_edge();
        set_inputs(1, 1, 4, 0, 0, 0, 0, 1, 4, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL simul_stall got=%b exp=0", stall); end
        clock_edge();
        checks++; if (pending !== 8'h10) begin failures++; $display("FAIL simul_pending got=%h exp=10", pending); end
        set_inputs(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        clock_edge();
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL simul_drain got=%h exp=00", pending); end
        checks++; if (wb_error !== 1'b0) begin failures++; $display("FAIL simul_no_error got=%b exp=0", wb_error); end
        idle_inputs();
    endtask

    task automatic test_spurious_wb();
        do_reset();
        set_inputs(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        clock_edge();
        set_inputs(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        clock_edge();
        checks++; if (wb_error !== 1'b1) begin failures++; $display("FAIL spur_error got=%b exp=1", wb_error); end
        checks++; if (pending !== 8'h02) begin failures++; $display("FAIL spur_pending got=%h exp=02", pending); end
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        clock_edge();
        checks++; if (wb_error !== 1'b1) begin failures++; $display("FAIL spur_after_flush got=%b exp=1", wb_error); end
        do_reset();
        checks++; if (wb_error !== 1'b0) begin failures++; $display("FAIL spur_after_reset got=%b exp=0", wb_error); end
    endtask

    task automatic test_flush();
        logic [2:0] regs [3];
        do_reset();
        regs[0] = 1; regs[1] = 2; regs[2] = 5;
        for (int k = 0; k < 3; k++) begin
            set_inputs(1, 1, regs[k], 0, 0, 0, 0, 0, 0, 0);
            clock_edge();
        end
        set_inputs(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        clock_edge();
        checks++; if (pending !== 8'h26) begin failures++; $display("FAIL flush_setup got=%h exp=26", pending); end
        set_inputs(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
        clock_edge();
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL flush_pending got=%h exp=00", pending); end
        checks++; if (stall_cycles !== 16'(m_scnt)) begin failures++; $display("FAIL flush_keeps_stall_cycles got=%0d exp=%0d", stall_cycles, m_scnt); end
        idle_inputs();
    endtask

    task automatic test_random();
        int busy [$];
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [2:0] wa;
            busy.delete();
            for (int i = 0; i < 8; i++) if (m_cnt[i] > 0) busy.push_back(i);
            wa = 3'($urandom);
            if (busy.size() > 0 && $urandom_range(0, 3) != 0) wa = 3'(busy[$urandom_range(0, busy.size() - 1)]);
            if ($urandom_range(0, 60) == 0) begin
                @(negedge clock);
                #2;
                reset = 1;
                #1;
                model_clear();
                checks++; if (pending !== 8'h00 || wb_error !== 1'b0 || stall_cycles !== 16'd0) begin
                    failures++; $display("FAIL rand_async_reset got=%h/%b/%0d exp=00/0/0", pending, wb_error, stall_cycles);
                end
                reset = 0;
            end
            set_inputs(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom),
                       1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
                       1'($urandom_range(0, 2) == 0), wa, 1'($urandom_range(0, 40) == 0));
            checks++; if (stall !== model_stall()) begin failures++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall, model_stall()); end
            clock_edge();
            checks++; if (pending !== model_pending()) begin failures++; $display("FAIL rand_pending n=%0d got=%h exp=%h", n, pending, model_pending()); end
            checks++; if (wb_error !== m_err) begin failures++; $display("FAIL rand_wb_error n=%0d got=%b exp=%b", n, wb_error, m_err); end
            checks++; if (stall_cycles !== 16'(m_scnt)) begin failures++; $display("FAIL rand_stall_cycles n=%0d got=%0d exp=%0d", n, stall_cycles, m_scnt); end
        end
        idle_inputs();
    endtask

    initial begin
        model_clear();
        idle_inputs();
        test_reset();
        test_raw();
        test_saturation();
        test_simultaneous();
        test_spurious_wb();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
